spi_word_loader: RTL and testbench
==================================

// Module: spi_word_loader
// PURPOSE
// - Parametrised SPI-style serial word receiver that feeds the SoC boot/instruction loader; successor to the fixed 1-bit, 32-bit SPI load path.
// - Samples spi_ss_i/spi_d_i on clk_i. These inputs are synchronous to clk_i (driven on its falling edge), so no synchronisers are used.
// - Deserialises DATA_WIDTH-bit words over LANES data lines, MSB first, and tags each word with an incrementing byte address.
// - Buffers words in a small FIFO and offers them on a valid/ready port toward the ICCM/DCCM write master. Reports overflow and truncated-word errors.
// PARAMETERS
// DATA_WIDTH  32  word width in bits; must be a multiple of 8 and of LANES
// LANES       1   serial data lines: 1, 2 or 4
// FIFO_DEPTH  4   word buffer entries; power of 2, >=2
// ADDR_WIDTH  16  width of the word address and of the word counter
// BASE_ADDR   0   byte address of the first word after reset or clear
// PORTS
// clk_i         in   1              system clock
// rst_ni        in   1              synchronous reset, active low
// clear_i       in   1              sync clear: counters, flags, FIFO, state
// spi_ss_i      in   1              frame select, active low
// spi_d_i       in   LANES          serial data; lane LANES-1 carries the most significant bit of each beat
// word_valid_o  out  1              FIFO head valid
// word_ready_i  in   1              consumer accepts the head word
// word_data_o   out  DATA_WIDTH     head word
// word_addr_o   out  ADDR_WIDTH     byte address of the head word
// word_count_o  out  ADDR_WIDTH     words accepted into the FIFO
// busy_o        out  1              frame active (state SHIFT)
// overflow_o    out  1              sticky: a word was dropped because the FIFO was full
// frag_o        out  1              sticky: ss_i rose with a partial word pending
// BEHAVIOUR
// - Reset (rst_ni=0 at posedge) and clear_i=1 have identical effect. All outputs go to 0, the FIFO empties, and the next address becomes BASE_ADDR.
// - Reset has priority over clear_i. Both abort any word in progress without setting frag_o.
// - BEATS = DATA_WIDTH/LANES. State is IDLE or SHIFT.
// - IDLE -> SHIFT on a posedge that samples ss_i=0. That same edge shifts in beat 0.
// - SHIFT: on each posedge with ss_i=0, shift_reg <= {shift_reg, spi_d_i} and increment beat_cnt.
// - On the last beat (beat_cnt==BEATS-1) the completed word is pushed and beat_cnt returns to 0. State stays SHIFT, so back-to-back words need no gap.
// - SHIFT -> IDLE when ss_i=1 is sampled.
//   - If beat_cnt!=0, the partial word is discarded and frag_o is set.
//   - If beat_cnt==0, no error.
// - Push:
//   - Pushed word gets address = next_addr. Then next_addr += DATA_WIDTH/8 and word_count_o += 1.
//   - Both wrap modulo 2^ADDR_WIDTH.
//   - The address is retained across frames; only reset or clear_i rewinds it.
// - FIFO full at push:
//   - If word_ready_i=0 in that cycle: the word is dropped and overflow_o is set. next_addr and word_count_o do not change.
//   - If word_ready_i=1 in that cycle (simultaneous pop): the push is accepted and there is no overflow.
// - The FIFO is show-ahead. word_valid_o = !empty, and word_data_o/word_addr_o come from the head entry.
// - A pop occurs when valid && ready. Head data must stay stable while valid && !ready.
// - Latency: with the FIFO empty, a last beat sampled at edge k gives word_valid_o=1 after edge k (visible in cycle k+1).
// - Push and pop in the same cycle with the FIFO empty: the pop sees empty and does nothing; the word appears the next cycle.
// - Sticky flags clear only on reset or clear_i.
// STRUCTURE
// - Package spi_loader_pkg:
//   - state enum {IDLE, SHIFT}
//   - function beats(DATA_WIDTH, LANES)
//   - parameter legality checks (LANES in {1,2,4}; DATA_WIDTH%8==0 and DATA_WIDTH%LANES==0)
// - Sub-module spi_loader_fifo: sync FIFO holding {addr, data}, WIDTH/DEPTH parameters, sync active-low reset plus clear input, full/empty outputs.
// - Top level: FSM, shift register, beat counter, address/word counters, error flags, FIFO instance.
// TESTING
// 1. LANES=1, ready=1: ss low, then 0xDEADBEEF MSB first over 32 cycles -> one word_valid pulse, data 0xDEADBEEF, addr 0x0, word_count_o=1.
// 2. Three words back-to-back in one frame (0x11111111, 0x22222222, 0x33333333) -> addrs 0x0/0x4/0x8, count 3, frag_o=0.
// 3. ss rises after 10 bits, then a full frame with 0xCAFEF00D -> frag_o=1, no word from the fragment; next word 0xCAFEF00D at addr 0x0.
// 4. FIFO_DEPTH=4, ready=0, 5 words -> overflow_o=1, count 4. Raise ready -> words 0-3 drain in order, addrs 0x0-0xC.
// 5. LANES=4: 0x12345678 in 8 beats (nibbles 1,2,...,8) -> word valid after the 8th beat, addr 0x0. Full FIFO with ready=1 on push cycle -> no overflow.
// 6. rst_ni low for 1 cycle mid-word (bit 17), then a new word 0xA5A5A5A5 -> all outputs 0 after reset, frag_o=0, word at addr 0x0.

Source files
------------

// File: rtl/spi_loader_pkg.sv
// ---------------------------------------------------------------------------
// spi_loader_pkg
// Shared types and elaboration-time helpers for the SPI word loader.
//   state_t      : receiver state (IDLE between frames, SHIFT inside a frame)
//   beats()      : number of serial beats that make up one word
//   *_legal()    : parameter legality predicates used by the top level
// ---------------------------------------------------------------------------
package spi_loader_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Beats per word: each beat moves one bit on every lane.
  function automatic int beats(input int data_width, input int lanes);
    return data_width / lanes;
  endfunction

  function automatic bit lanes_legal(input int lanes);
    return (lanes == 1) || (lanes == 2) || (lanes == 4);
  endfunction

  // Word must be whole bytes (byte addressing) and a whole number of beats.
  function automatic bit width_legal(input int data_width, input int lanes);
    return (data_width > 0) && (data_width % 8 == 0) && (data_width % lanes == 0);
  endfunction

  function automatic bit depth_legal(input int depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/spi_loader_fifo.sv
// ---------------------------------------------------------------------------
// spi_loader_fifo
// Show-ahead synchronous FIFO holding {addr, data} entries for the loader.
//   clk        : clock
//   rst_n      : synchronous reset, active low
//   clear      : synchronous flush (same effect as reset)
//   push       : write push_data this cycle (caller guarantees room, which
//                includes the full-with-simultaneous-pop case)
//   push_data  : entry to write
//   pop        : consumer ready; an entry leaves only when not empty
//   pop_data   : head entry, forced to zero while empty
//   full/empty : occupancy flags
// ---------------------------------------------------------------------------
module spi_loader_fifo #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  // Tiny buffer read combinationally so the head is visible the cycle after
  // the write; a registered-read RAM would add a cycle of latency.
  logic [WIDTH-1:0] mem [DEPTH];

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0] wr_ptr_reg;
  logic [AW:0] rd_ptr_reg;
  logic        do_pop;

  assign empty  = (wr_ptr_reg == rd_ptr_reg);
  assign full   = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                  (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign do_pop = pop && !empty;

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
      end
    end
  end

  // Storage is not reset; the empty gate below hides stale contents.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg[AW-1:0]] <= push_data;
    end
  end

  assign pop_data = empty ? '0 : mem[rd_ptr_reg[AW-1:0]];

endmodule

// File: rtl/spi_word_loader.sv
// ---------------------------------------------------------------------------
// spi_word_loader
// Serial word receiver for the boot/instruction loader. Deserialises
// DATA_WIDTH-bit words, MSB first, over LANES data lines while spi_ss_i is
// low, tags each word with an incrementing byte address and offers it on a
// valid/ready port through a small show-ahead FIFO.
//   clk_i        : system clock (serial inputs are synchronous to it)
//   rst_ni       : synchronous reset, active low (priority over clear_i)
//   clear_i      : synchronous clear, same effect as reset
//   spi_ss_i     : frame select, active low
//   spi_d_i      : serial data, lane LANES-1 is the MSB of each beat
//   word_valid_o : head word valid
//   word_ready_i : consumer accepts the head word
//   word_data_o  : head word
//   word_addr_o  : byte address of the head word
//   word_count_o : words accepted into the FIFO
//   busy_o       : frame in progress
//   overflow_o   : sticky, a word was dropped on a full FIFO
//   frag_o       : sticky, frame ended with a partial word
// ---------------------------------------------------------------------------
module spi_word_loader
  import spi_loader_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    LANES      = 1,
  parameter int                    FIFO_DEPTH = 4,
  parameter int                    ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic                  spi_ss_i,
  input  logic [LANES-1:0]      spi_d_i,
  output logic                  word_valid_o,
  input  logic                  word_ready_i,
  output logic [DATA_WIDTH-1:0] word_data_o,
  output logic [ADDR_WIDTH-1:0] word_addr_o,
  output logic [ADDR_WIDTH-1:0] word_count_o,
  output logic                  busy_o,
  output logic                  overflow_o,
  output logic                  frag_o
);

  localparam int BEATS = beats(DATA_WIDTH, LANES);
  localparam int BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int EW    = ADDR_WIDTH + DATA_WIDTH;

  generate
    if (!lanes_legal(LANES) || !width_legal(DATA_WIDTH, LANES) ||
        !depth_legal(FIFO_DEPTH)) begin : g_param_error
      $error("spi_word_loader: illegal LANES/DATA_WIDTH/FIFO_DEPTH");
    end
  endgenerate

  state_t                  state_reg;
  logic [DATA_WIDTH-1:0]   shift_reg;
  logic [DATA_WIDTH-1:0]   shift_next;
  logic [BCW-1:0]          beat_cnt_reg;
  logic [ADDR_WIDTH-1:0]   next_addr_reg;
  logic [ADDR_WIDTH-1:0]   word_count_reg;
  logic                    overflow_reg;
  logic                    frag_reg;

  logic                    sample_beat;
  logic                    last_beat;
  logic                    push_req;
  logic                    push_ok;
  logic                    push_drop;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [EW-1:0]           fifo_head;

  // A beat is taken on every edge with select low, whether the frame is just
  // starting (IDLE) or already running (SHIFT). beat_cnt_reg is always zero
  // in IDLE, so the starting edge naturally becomes beat 0.
  assign sample_beat = !spi_ss_i;
  assign shift_next  = {shift_reg[DATA_WIDTH-LANES-1:0], spi_d_i};
  assign last_beat   = (beat_cnt_reg == BCW'(BEATS - 1));
  assign push_req    = sample_beat && last_beat;

  // A full FIFO still takes the word when the head leaves in the same cycle
  // (full implies valid, so ready alone means a pop happens).
  assign push_ok     = push_req && (!fifo_full || word_ready_i);
  assign push_drop   = push_req && fifo_full && !word_ready_i;

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      state_reg      <= IDLE;
      shift_reg      <= '0;
      beat_cnt_reg   <= '0;
      next_addr_reg  <= BASE_ADDR;
      word_count_reg <= '0;
      overflow_reg   <= 1'b0;
      frag_reg       <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (!spi_ss_i) begin
            state_reg <= SHIFT;
          end
        end
        SHIFT: begin
          if (spi_ss_i) begin
            state_reg <= IDLE;
            // Frame ended between word boundaries: partial word is lost.
            if (beat_cnt_reg != '0) begin
              frag_reg <= 1'b1;
            end
          end
        end
      endcase

      if (sample_beat) begin
        shift_reg    <= shift_next;
        beat_cnt_reg <= last_beat ? '0 : beat_cnt_reg + BCW'(1);
      end else begin
        beat_cnt_reg <= '0;
      end

      // Address and count only advance for words that actually entered.
      if (push_ok) begin
        next_addr_reg  <= next_addr_reg + ADDR_WIDTH'(BYTES);
        word_count_reg <= word_count_reg + ADDR_WIDTH'(1);
      end

      if (push_drop) begin
        overflow_reg <= 1'b1;
      end
    end
  end

  spi_loader_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk_i),
    .rst_n     (rst_ni),
    .clear     (clear_i),
    .push      (push_ok),
    .push_data ({next_addr_reg, shift_next}),
    .pop       (word_ready_i),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign word_valid_o = !fifo_empty;
  assign word_data_o  = fifo_head[DATA_WIDTH-1:0];
  assign word_addr_o  = fifo_head[EW-1:DATA_WIDTH];
  assign word_count_o = word_count_reg;
  assign busy_o       = (state_reg == SHIFT);
  assign overflow_o   = overflow_reg;
  assign frag_o       = frag_reg;

endmodule

// File: tb/tb_spi_word_loader.sv
// ---------------------------------------------------------------------------
// tb_spi_word_loader
// Two loaders side by side: instance 0 with one lane, instance 1 with four.
// Each has a behavioural model (bit accumulator + queue) compared on every
// cycle, plus directed literal checks from the main sequence.
// ---------------------------------------------------------------------------
module tb_spi_word_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        clear;
  logic        ss     [2];
  logic        ready  [2];
  logic [3:0]  d_bus  [2];
  logic        valid_w[2];
  logic [31:0] data_w [2];
  logic [15:0] addr_w [2];
  logic [15:0] count_w[2];
  logic        busy_w [2];
  logic        ovf_w  [2];
  logic        frag_w [2];

  int total = 0;
  int bad   = 0;
  bit check_en = 1'b0;

  task automatic chk(input string name, input int inst,
                     input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s inst%0d: got %h expected %h", name, inst, act, exp);
    end
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_inst
    localparam int L = (gi == 0) ? 1 : 4;

    spi_word_loader #(
      .DATA_WIDTH (32),
      .LANES      (L),
      .FIFO_DEPTH (4),
      .ADDR_WIDTH (16),
      .BASE_ADDR  (16'h0000)
    ) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .clear_i      (clear),
      .spi_ss_i     (ss[gi]),
      .spi_d_i      (d_bus[gi][L-1:0]),
      .word_valid_o (valid_w[gi]),
      .word_ready_i (ready[gi]),
      .word_data_o  (data_w[gi]),
      .word_addr_o  (addr_w[gi]),
      .word_count_o (count_w[gi]),
      .busy_o       (busy_w[gi]),
      .overflow_o   (ovf_w[gi]),
      .frag_o       (frag_w[gi])
    );

    // Model: count received bits, keep accepted words as {addr,data} in a queue.
    logic [47:0] m_q[$];
    logic [63:0] m_acc;
    int          m_bits;
    logic [15:0] m_addr;
    logic [15:0] m_count;
    bit          m_busy;
    bit          m_ovf;
    bit          m_frag;

    always @(posedge clk) begin : model
      bit popped;
      int occ;
      if (!rst_n || clear) begin
        m_q.delete();
        m_acc   = '0;
        m_bits  = 0;
        m_addr  = 16'h0000;
        m_count = 16'h0000;
        m_busy  = 1'b0;
        m_ovf   = 1'b0;
        m_frag  = 1'b0;
      end else begin
        occ    = m_q.size();
        popped = (occ != 0) && ready[gi];
        if (popped) begin
          $display("pop inst%0d addr=%h data=%h", gi, m_q[0][47:32], m_q[0][31:0]);
          void'(m_q.pop_front());
        end
        if (!ss[gi]) begin
          m_busy = 1'b1;
          m_acc  = (m_acc << L) | 64'(d_bus[gi][L-1:0]);
          m_bits = m_bits + L;
          if (m_bits == 32) begin
            m_bits = 0;
            if (occ < 4 || ready[gi]) begin
              m_q.push_back({m_addr, m_acc[31:0]});
              m_addr  = m_addr + 16'd4;
              m_count = m_count + 16'd1;
            end else begin
              m_ovf = 1'b1;
            end
          end
        end else begin
          if (m_bits != 0) m_frag = 1'b1;
          m_bits = 0;
          m_busy = 1'b0;
        end
      end
    end

    always @(negedge clk) begin : compare
      if (check_en) begin
        chk("m_valid", gi, 64'(valid_w[gi]), 64'(m_q.size() != 0));
        if (m_q.size() != 0) begin
          chk("m_data", gi, 64'(data_w[gi]), 64'(m_q[0][31:0]));
          chk("m_addr", gi, 64'(addr_w[gi]), 64'(m_q[0][47:32]));
        end
        chk("m_count", gi, 64'(count_w[gi]), 64'(m_count));
        chk("m_busy",  gi, 64'(busy_w[gi]),  64'(m_busy));
        chk("m_ovf",   gi, 64'(ovf_w[gi]),   64'(m_ovf));
        chk("m_frag",  gi, 64'(frag_w[gi]),  64'(m_frag));
      end
    end
  end

  // One drive/check point per cycle, 2 time units after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic send_bits(input int inst, input logic [31:0] w, input int nbits);
    int l;
    logic [31:0] sh;
    l = (inst == 0) ? 1 : 4;
    for (int b = 0; b < nbits / l; b++) begin
      cyc();
      sh = w >> (32 - l * (b + 1));
      ss[inst]    = 1'b0;
      d_bus[inst] = sh[3:0] & ((inst == 0) ? 4'h1 : 4'hF);
    end
  endtask

  task automatic send_word(input int inst, input logic [31:0] w);
    send_bits(inst, w, 32);
  endtask

  task automatic do_clear();
    cyc();
    ss[0] = 1'b1; ss[1] = 1'b1;
    d_bus[0] = 4'h0; d_bus[1] = 4'h0;
    clear = 1'b1;
    cyc();
    clear = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  logic [31:0] w4 [5];
  logic [31:0] w5 [5];

  initial begin : main
    rst_n = 1'b0;
    clear = 1'b0;
    for (int i = 0; i < 2; i++) begin
      ss[i] = 1'b1; ready[i] = 1'b0; d_bus[i] = 4'h0;
    end
    w4[0] = 32'h01020304; w4[1] = 32'h05060708; w4[2] = 32'h090A0B0C;
    w4[3] = 32'h0D0E0F10; w4[4] = 32'h11121314;
    w5[0] = 32'h12345678; w5[1] = 32'h0BADF00D; w5[2] = 32'h13579BDF;
    w5[3] = 32'h2468ACE0; w5[4] = 32'hFEDCBA98;

    // Reset state
    cyc();
    cyc();
    for (int i = 0; i < 2; i++) begin
      chk("rst_valid", i, 64'(valid_w[i]), 64'd0);
      chk("rst_count", i, 64'(count_w[i]), 64'd0);
      chk("rst_busy",  i, 64'(busy_w[i]),  64'd0);
      chk("rst_ovf",   i, 64'(ovf_w[i]),   64'd0);
      chk("rst_frag",  i, 64'(frag_w[i]),  64'd0);
    end
    rst_n    = 1'b1;
    check_en = 1'b1;

    // 1: single word, ready held high; visible one cycle then popped.
    ready[0] = 1'b1;
    send_word(0, 32'hDEADBEEF);
    cyc();
    chk("t1_valid", 0, 64'(valid_w[0]), 64'd1);
    chk("t1_data",  0, 64'(data_w[0]),  64'hDEADBEEF);
    chk("t1_addr",  0, 64'(addr_w[0]),  64'h0);
    chk("t1_count", 0, 64'(count_w[0]), 64'd1);
    ss[0] = 1'b1; d_bus[0] = 4'h0;
    cyc();
    chk("t1_pulse", 0, 64'(valid_w[0]), 64'd0);
    chk("t1_busy",  0, 64'(busy_w[0]),  64'd0);
    chk("t1_frag",  0, 64'(frag_w[0]),  64'd0);

    // 2: three back-to-back words in one frame, drained afterwards.
    do_clear();
    ready[0] = 1'b0;
    send_word(0, 32'h11111111);
    send_word(0, 32'h22222222);
    send_word(0, 32'h33333333);
    cyc();
    ss[0] = 1'b1; d_bus[0] = 4'h0;
    chk("t2_count", 0, 64'(count_w[0]), 64'd3);
    for (int i = 0; i < 3; i++) begin
      chk("t2_data", 0, 64'(data_w[0]), 64'(32'h11111111 * (i + 1)));
      chk("t2_addr", 0, 64'(addr_w[0]), 64'(4 * i));
      ready[0] = 1'b1;
      cyc();
    end
    chk("t2_empty", 0, 64'(valid_w[0]), 64'd0);
    chk("t2_frag",  0, 64'(frag_w[0]),  64'd0);
    ready[0] = 1'b0;

    // 3: 10-bit fragment, then a full frame.
    do_clear();
    ready[0] = 1'b1;
    send_bits(0, 32'hFFC00000, 10);
    cyc();
    ss[0] = 1'b1; d_bus[0] = 4'h0;
    cyc();
    chk("t3_frag",  0, 64'(frag_w[0]),  64'd1);
    chk("t3_nowd",  0, 64'(valid_w[0]), 64'd0);
    chk("t3_cnt0",  0, 64'(count_w[0]), 64'd0);
    send_word(0, 32'hCAFEF00D);
    cyc();
    chk("t3_valid", 0, 64'(valid_w[0]), 64'd1);
    chk("t3_data",  0, 64'(data_w[0]),  64'hCAFEF00D);
    chk("t3_addr",  0, 64'(addr_w[0]),  64'h0);
    ss[0] = 1'b1; d_bus[0] = 4'h0;
    cyc();

    // 4: five words into a 4-deep FIFO with ready low.
    do_clear();
    ready[0] = 1'b0;
    for (int i = 0; i < 5; i++) send_word(0, w4[i]);
    cyc();
    ss[0] = 1'b1; d_bus[0] = 4'h0;
    chk("t4_ovf",   0, 64'(ovf_w[0]),   64'd1);
    chk("t4_count", 0, 64'(count_w[0]), 64'd4);
    for (int i = 0; i < 4; i++) begin
      chk("t4_valid", 0, 64'(valid_w[0]), 64'd1);
      chk("t4_data",  0, 64'(data_w[0]),  64'(w4[i]));
      chk("t4_addr",  0, 64'(addr_w[0]),  64'(4 * i));
      ready[0] = 1'b1;
      cyc();
    end
    chk("t4_empty", 0, 64'(valid_w[0]), 64'd0);
    ready[0] = 1'b0;

    // 5: four lanes; then push into a full FIFO while the head pops.
    do_clear();
    ready[1] = 1'b1;
    send_word(1, w5[0]);
    cyc();
    chk("t5_valid", 1, 64'(valid_w[1]), 64'd1);
    chk("t5_data",  1, 64'(data_w[1]),  64'h12345678);
    chk("t5_addr",  1, 64'(addr_w[1]),  64'h0);
    ss[1] = 1'b1; d_bus[1] = 4'h0;
    ready[1] = 1'b0;
    for (int i = 1; i < 4; i++) send_word(1, w5[i]);
    send_word(1, w5[4]);
    ready[1] = 1'b1;
    cyc();
    ready[1] = 1'b0;
    ss[1] = 1'b1; d_bus[1] = 4'h0;
    chk("t5_noovf", 1, 64'(ovf_w[1]),   64'd0);
    chk("t5_count", 1, 64'(count_w[1]), 64'd5);
    for (int i = 1; i < 5; i++) begin
      chk("t5_hdata", 1, 64'(data_w[1]), 64'(w5[i]));
      chk("t5_haddr", 1, 64'(addr_w[1]), 64'(4 * i));
      ready[1] = 1'b1;
      cyc();
    end
    chk("t5_empty", 1, 64'(valid_w[1]), 64'd0);
    ready[1] = 1'b0;

    // 6: reset mid-word (after 17 bits), then a fresh word.
    do_clear();
    ready[0] = 1'b0;
    send_bits(0, 32'hFFFF8000, 17);
    cyc();
    rst_n = 1'b0;
    cyc();
    chk("t6_valid", 0, 64'(valid_w[0]), 64'd0);
    chk("t6_data",  0, 64'(data_w[0]),  64'd0);
    chk("t6_addr",  0, 64'(addr_w[0]),  64'd0);
    chk("t6_count", 0, 64'(count_w[0]), 64'd0);
    chk("t6_busy",  0, 64'(busy_w[0]),  64'd0);
    chk("t6_ovf",   0, 64'(ovf_w[0]),   64'd0);
    chk("t6_frag",  0, 64'(frag_w[0]),  64'd0);
    rst_n = 1'b1;
    ss[0] = 1'b1; d_bus[0] = 4'h0;
    cyc();
    send_word(0, 32'hA5A5A5A5);
    cyc();
    chk("t6_wvalid", 0, 64'(valid_w[0]), 64'd1);
    chk("t6_wdata",  0, 64'(data_w[0]),  64'hA5A5A5A5);
    chk("t6_waddr",  0, 64'(addr_w[0]),  64'h0);
    chk("t6_wfrag",  0, 64'(frag_w[0]),  64'd0);
    ss[0] = 1'b1; d_bus[0] = 4'h0;
    ready[0] = 1'b1;
    cyc();
    cyc();
    chk("t6_drained", 0, 64'(valid_w[0]), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
